// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, constants, FSM states and operand classes
// for the FP datapath blocks.
package fp32_pkg;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [30:0] INF_MAG = 31'h7F800000;

    typedef enum logic [1:0] {IDLE, DIV, PACK, DONE} state_t;
    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} opclass_t;

    // Denormals collapse to ZERO: this datapath has no subnormal support.
    function automatic opclass_t classify(input logic [30:0] mag);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        e = mag[30:23];
        m = mag[22:0];
        if (e == '0)
            return ZERO;
        else if (e == EXP_MAX[EXP_W-1:0])
            return (m == '0) ? INF : NAN;
        else
            return NORM;
    endfunction
endpackage

// File: rtl/fp_mant_div_step.sv
// One restoring-division step on 24-bit hidden-one mantissas: compare,
// conditionally subtract, then shift the partial remainder left.
module fp_mant_div_step (
    input  logic [24:0] r_i,
    input  logic [23:0] mb_i,
    output logic [24:0] r_o,
    output logic        q_o
);
    logic [24:0] diff;

    always_comb begin
        diff = r_i - {1'b0, mb_i};
        q_o  = (r_i >= {1'b0, mb_i});
        // The remainder stays below 2*Mb, so bit 24 is always zero before the shift.
        r_o  = q_o ? {diff[23:0], 1'b0} : {r_i[23:0], 1'b0};
    end
endmodule

// File: rtl/seq_fp_divider.sv
// Sequential binary32 divider: one quotient bit per cycle by restoring
// division, truncating result, fixed latency for normal and special operands.
module seq_fp_divider
    import fp32_pkg::*;
#(
    parameter int N      = 32,
    parameter int Q_BITS = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Result,
    output logic         Overflow,
    output logic         UnderFlow,
    output logic         Zero,
    output logic         DivByZero
);
    state_t              state_q, state_d;
    opclass_t            cls_a_q, cls_a_d, cls_b_q, cls_b_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [24:0]         r_q, r_d;
    logic [23:0]         mb_q, mb_d;
    logic [Q_BITS-1:0]   q_q, q_d;
    logic signed [9:0]   exp_q, exp_d;
    logic                sign_q, sign_d;
    logic [N-1:0]        result_q, result_d;
    logic                ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d, dbz_q, dbz_d;
    logic                done_q, done_d;

    logic [24:0]         step_r;
    logic                step_q;
    logic signed [9:0]   exp_n;
    logic [MANT_W-1:0]   mant_n;

    fp_mant_div_step u_step (
        .r_i  (r_q),
        .mb_i (mb_q),
        .r_o  (step_r),
        .q_o  (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cls_a_d  = cls_a_q;
        cls_b_d  = cls_b_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        mb_d     = mb_q;
        q_d      = q_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        // A quotient below 1.0 needs one left shift and an exponent decrement.
        exp_n  = q_q[Q_BITS-1] ? exp_q : exp_q - 10'sd1;
        mant_n = q_q[Q_BITS-1] ? q_q[23:1] : q_q[22:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIV;
                    cnt_d   = 5'd24;
                    sign_d  = A[31] ^ B[31];
                    cls_a_d = classify(A[30:0]);
                    cls_b_d = classify(B[30:0]);
                    r_d     = {2'b01, A[22:0]};
                    mb_d    = {1'b1, B[22:0]};
                    q_d     = '0;
                    exp_d   = $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]})
                              + 10'sd127;
                end
            end
            DIV: begin
                r_d   = step_r;
                q_d   = {q_q[Q_BITS-2:0], step_q};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0)
                    state_d = PACK;
            end
            PACK: begin
                state_d = DONE;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                zero_d  = 1'b0;
                dbz_d   = 1'b0;
                if (cls_a_q == NAN || cls_b_q == NAN ||
                    (cls_a_q == ZERO && cls_b_q == ZERO) ||
                    (cls_a_q == INF && cls_b_q == INF)) begin
                    result_d = QNAN;
                end else if (cls_a_q == INF) begin
                    result_d = {sign_q, INF_MAG};
                end else if (cls_b_q == ZERO) begin
                    result_d = {sign_q, INF_MAG};
                    ovf_d    = 1'b1;
                    dbz_d    = 1'b1;
                end else if (cls_a_q == ZERO || cls_b_q == INF) begin
                    result_d = {sign_q, 31'd0};
                    zero_d   = 1'b1;
                end else if (exp_n >= 10'sd255) begin
                    result_d = {sign_q, INF_MAG};
                    ovf_d    = 1'b1;
                end else if (exp_n <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                    zero_d   = 1'b1;
                end else begin
                    result_d = {sign_q, exp_n[7:0], mant_n};
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cls_a_q  <= ZERO;
            cls_b_q  <= ZERO;
            cnt_q    <= '0;
            r_q      <= '0;
            mb_q     <= '0;
            q_q      <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_a_q  <= cls_a_d;
            cls_b_q  <= cls_b_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            mb_q     <= mb_d;
            q_q      <= q_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign Result    = result_q;
    assign Overflow  = ovf_q;
    assign UnderFlow = unf_q;
    assign Zero      = zero_q;
    assign DivByZero = dbz_q;
endmodule

// File: tb/tb_seq_fp_divider.sv
// Scoreboard bench for seq_fp_divider: directed operands with hand-computed
// quotients, latency, busy, back-pressure on start and mid-operation reset.
module tb_seq_fp_divider;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] Result;
    logic        Overflow, UnderFlow, Zero, DivByZero;

    seq_fp_divider dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Result    (Result),
        .Overflow  (Overflow),
        .UnderFlow (UnderFlow),
        .Zero      (Zero),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   txn = 0;
    logic busy_gap = 1'b0;

    // flag order: {Overflow, UnderFlow, Zero, DivByZero}
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done got=1 want=0");
                end else begin
                    e = sb.pop_front();
                    txn++;
                    $display("txn %0d A=%h B=%h Result=%h flags=%b latency=%0d",
                             txn, e.a, e.b, Result,
                             {Overflow, UnderFlow, Zero, DivByZero}, cyc - e.acc);
                    check("result", Result, e.res);
                    check("flags", {28'd0, Overflow, UnderFlow, Zero, DivByZero}, {28'd0, e.flg});
                    check("latency", cyc - e.acc, 32'd27);
                    check("busy_held", {31'd0, busy_gap}, 32'd0);
                    busy_gap = 1'b0;
                end
            end else if (sb.size() != 0 && !busy) begin
                busy_gap = 1'b1;
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input logic [3:0] flg);
        exp_t x;
        x.res = res;
        x.flg = flg;
        x.acc = cyc;
        x.a   = a;
        x.b   = b;
        sb.push_back(x);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout got=pending want=done");
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] flg);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push_exp(a, b, res, flg);
        wait_done();
    endtask

    int d0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", Result, 32'd0);
        check("reset_flags", {28'd0, Overflow, UnderFlow, Zero, DivByZero}, 32'd0);

        run(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000); // 6/2
        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000); // 1/3 truncated
        run(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000); // -6/2
        run(32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000); // 3/2
        run(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000); // 1/1
        run(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1001); // x/0
        run(32'h3F800000, 32'h80000000, 32'hFF800000, 4'b1001); // x/-0
        run(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0000); // 0/0
        run(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000); // exp overflow
        run(32'h00800000, 32'h40000000, 32'h00000000, 4'b0110); // exp underflow
        run(32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000); // inf/x
        run(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0000); // inf/inf
        run(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0000); // NaN in
        run(32'h00000000, 32'hC0000000, 32'h80000000, 4'b0010); // 0/-2
        run(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0010); // x/inf
        run(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0010); // denormal as zero

        // start held high while busy with changing operands
        d0 = done_cnt;
        @(negedge clk);
        A = 32'h40C00000;
        B = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        push_exp(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            A = 32'h3F800000 + i;
            B = 32'h40400000;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("single_done", done_cnt - d0, 32'd1);

        // mid-operation reset aborts without a done pulse
        @(negedge clk);
        A = 32'h3F800000;
        B = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", Result, 32'd0);
        sb.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 32'd0);

        run(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
